// File: rtl/wb_pkg.sv
// Shared types for the writeback/retire queue: load classes,
// queue entry layout and the load-class decoder.
package wb_pkg;

  typedef enum logic [3:0] {
    LD_NONE = 4'd0,
    LD_W,
    LD_H,
    LD_HU,
    LD_B,
    LD_BU,
    LD_WL,
    LD_WR,
    LD_ST
  } ld_op_t;

  typedef struct packed {
    logic [31:0] pc;
    ld_op_t      ldop;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [1:0]  eoff;
    logic [31:0] rtold;
    logic        kill;
  } wb_entry_t;

  // funct is the low three opcode bits of a MIPS load
  function automatic ld_op_t ld_op_decode(
    input logic       load,
    input logic       store,
    input logic [2:0] funct
  );
    ld_op_t op;
    op = LD_NONE;
    if (store) begin
      op = LD_ST;
    end else if (load) begin
      unique case (funct)
        3'b000:  op = LD_B;
        3'b001:  op = LD_H;
        3'b010:  op = LD_WL;
        3'b011:  op = LD_W;
        3'b100:  op = LD_BU;
        3'b101:  op = LD_HU;
        3'b110:  op = LD_WR;
        default: op = LD_W;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: byte/half extraction with extension and
// the LWL/LWR merge over the old rt value.
module wb_load_align
  import wb_pkg::*;
(
  input  ld_op_t      ldop,
  input  logic [1:0]  eoff,
  input  logic [31:0] rdata,
  input  logic [31:0] rtold,
  output logic [31:0] wdata
);

  logic [4:0]  sr;
  logic [4:0]  sl;
  logic [31:0] shr;
  logic [31:0] lmask;
  logic [31:0] rmask;

  assign sr    = {eoff, 3'b000};
  assign sl    = {~eoff, 3'b000};
  assign shr   = rdata >> sr;
  assign lmask = 32'hFFFF_FFFF << sl;
  assign rmask = 32'hFFFF_FFFF >> sr;

  always_comb begin
    wdata = rdata;
    unique case (ldop)
      LD_B:    wdata = {{24{shr[7]}}, shr[7:0]};
      LD_BU:   wdata = {24'd0, shr[7:0]};
      LD_H:    wdata = {{16{shr[15]}}, shr[15:0]};
      LD_HU:   wdata = {16'd0, shr[15:0]};
      LD_WL:   wdata = (rdata << sl) | (rtold & ~lmask);
      LD_WR:   wdata = shr | (rtold & ~rmask);
      default: wdata = rdata;
    endcase
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback/retire queue with pending-write scoreboard.
// Optional same-cycle ALU retire when empty: define WB_BYPASS_EN.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [3:0]       in_ldop,
  input  logic             in_wen,
  input  logic [4:0]       in_waddr,
  input  logic [31:0]      in_result,
  input  logic [1:0]       in_eoff,
  input  logic [31:0]      in_rtold,
  input  logic             flush,
  input  logic [31:0]      data_rdata,
  input  logic             data_data_ok,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             retire_valid,
  output logic [31:0]      retire_pc,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t        q [DEPTH];
  wb_entry_t        h;
  wb_entry_t        nw;
  wb_entry_t        e;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CNT_W-1:0] cnt;
  logic             h_vld;
  logic             h_mem;
  logic             retire;
  logic             wr;
  logic             push;
  logic             byp;
  logic             stray;
  logic [31:0]      al_data;
  logic [31:0]      wdata_nx;

  assign h      = q[head];
  assign h_vld  = cnt != '0;
  assign h_mem  = h.ldop != LD_NONE;
  assign retire = h_vld && (!h_mem || data_data_ok);
  assign stray  = data_data_ok && !(h_vld && h_mem);
  assign wr     = retire && h.wen && !h.kill
                  && (h.ldop != LD_ST);

  assign in_ready = (cnt != CNT_W'(DEPTH)) && !flush;
  assign count    = cnt;

`ifdef WB_BYPASS_EN
  assign byp = (cnt == '0) && in_valid && !flush
               && (ld_op_t'(in_ldop) == LD_NONE);
`else
  assign byp = 1'b0;
`endif

  assign push = in_valid && in_ready && !byp;

  always_comb begin
    nw        = '0;
    nw.pc     = in_pc;
    nw.ldop   = ld_op_t'(in_ldop);
    nw.wen    = in_wen;
    nw.waddr  = in_waddr;
    nw.result = in_result;
    nw.eoff   = in_eoff;
    nw.rtold  = in_rtold;
    nw.kill   = 1'b0;
  end

  wb_load_align u_align (
    .ldop  (h.ldop),
    .eoff  (h.eoff),
    .rdata (data_rdata),
    .rtold (h.rtold),
    .wdata (al_data)
  );

  assign wdata_nx = h_mem ? al_data : h.result;

  // flush marks every slot; a push never coincides with flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) q[i].kill <= 1'b1;
      end
      if (push) begin
        q[tail] <= nw;
        tail    <= tail + 1'b1;
      end
      if (retire) head <= head + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(retire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      err          <= 1'b0;
    end else begin
      rf_wen       <= wr || (byp && in_wen);
      retire_valid <= retire || byp;
      err          <= err || stray;
      if (byp) begin
        rf_waddr  <= in_waddr;
        rf_wdata  <= in_result;
        retire_pc <= in_pc;
      end else if (retire) begin
        rf_waddr  <= h.waddr;
        rf_wdata  <= wdata_nx;
        retire_pc <= h.pc;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    e         = q[head];
    for (int i = 0; i < DEPTH; i++) begin
      e = q[head + PW'(i)];
      if ((CNT_W'(i) < cnt) && e.wen && !e.kill)
        busy_mask[e.waddr] = 1'b1;
    end
    if (rf_wen) busy_mask[rf_waddr] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue (default build, DEPTH=4):
// directed pushes enqueue expected writes, a monitor checks rf_*.
module tb_wb_retire_queue;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_ldop;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [31:0] in_result;
  logic [1:0]  in_eoff;
  logic [31:0] in_rtold;
  logic        flush;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] busy_mask;
  logic [2:0]  count;
  logic        err;

  wb_retire_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_ldop      (in_ldop),
    .in_wen       (in_wen),
    .in_waddr     (in_waddr),
    .in_result    (in_result),
    .in_eoff      (in_eoff),
    .in_rtold     (in_rtold),
    .flush        (flush),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .busy_mask    (busy_mask),
    .count        (count),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0] fill [4] = '{32'h0102_0304, 32'hA5A5_0011,
                            32'hDEAD_BEEF, 32'h0000_0042};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rf_wen) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rf_unexpected: got waddr %0d wdata %h want none",
                 rf_waddr, rf_wdata);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(x.a));
        chk("rf_wdata", rf_wdata, x.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t x;
    x.a = a;
    x.d = d;
    sbq.push_back(x);
  endtask

  task automatic push(input logic [31:0] pc, input ld_op_t op,
                      input logic wen, input logic [4:0] wa,
                      input logic [31:0] res, input logic [1:0] eo,
                      input logic [31:0] rt);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_ldop   = op;
    in_wen    = wen;
    in_waddr  = wa;
    in_result = res;
    in_eoff   = eo;
    in_rtold  = rt;
    cyc();
    in_valid  = 1'b0;
  endtask

  task automatic resp(input logic [31:0] rd);
    data_data_ok = 1'b1;
    data_rdata   = rd;
    cyc();
    data_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_pc        = '0;
    in_ldop      = '0;
    in_wen       = 1'b0;
    in_waddr     = '0;
    in_result    = '0;
    in_eoff      = '0;
    in_rtold     = '0;
    flush        = 1'b0;
    data_rdata   = '0;
    data_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // ALU op: visible at t+2, busy from t+1 through t+2
    cyc();
    expect_wr(5'd5, 32'h0000_1234);
    push(32'h0000_0100, LD_NONE, 1'b1, 5'd5, 32'h1234, 2'd0, 32'd0);
    @(negedge clk);
    chk("alu_busy_t1", 32'(busy_mask[5]), 32'd1);
    chk("alu_rfwen_t1", 32'(rf_wen), 32'd0);
    chk("alu_count_t1", 32'(count), 32'd1);
    @(negedge clk);
    chk("alu_busy_t2", 32'(busy_mask[5]), 32'd1);
    chk("alu_retire_valid", 32'(retire_valid), 32'd1);
    chk("alu_retire_pc", retire_pc, 32'h0000_0100);
    cyc();

    expect_wr(5'd7, 32'hFFFF_FF80);
    push(32'h104, LD_B, 1'b1, 5'd7, 32'd0, 2'd3, 32'd0);
    resp(32'h80FF_FF00);
    expect_wr(5'd8, 32'h0000_0080);
    push(32'h108, LD_BU, 1'b1, 5'd8, 32'd0, 2'd3, 32'd0);
    resp(32'h80FF_FF00);
    expect_wr(5'd9, 32'hCCDD_3344);
    push(32'h10C, LD_WL, 1'b1, 5'd9, 32'd0, 2'd1, 32'h1122_3344);
    resp(32'hAABB_CCDD);
    expect_wr(5'd10, 32'h1122_AABB);
    push(32'h110, LD_WR, 1'b1, 5'd10, 32'd0, 2'd2, 32'h1122_3344);
    resp(32'hAABB_CCDD);

    // fill to DEPTH, then drain one per cycle
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_wr(5'(11 + k), fill[k]);
      in_pc    = 32'h200 + 32'(4 * k);
      in_ldop  = LD_W;
      in_wen   = 1'b1;
      in_waddr = 5'(11 + k);
      in_eoff  = 2'd0;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      data_data_ok = 1'b1;
      data_rdata   = fill[k];
      if (k == 0) chk("full_ready_retire", 32'(in_ready), 32'd0);
      if (k == 1) chk("ready_after_retire", 32'(in_ready), 32'd1);
      cyc();
    end
    data_data_ok = 1'b0;

    // flushed loads consume their responses without writing
    push(32'h300, LD_W, 1'b1, 5'd15, 32'd0, 2'd0, 32'd0);
    push(32'h304, LD_H, 1'b1, 5'd16, 32'd0, 2'd0, 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy_mask, 32'd0);
    chk("flush_count", 32'(count), 32'd2);
    cyc();
    resp(32'h1111_1111);
    resp(32'h2222_2222);
    @(negedge clk);
    chk("flush_drained", 32'(count), 32'd0);
    chk("flush_err", 32'(err), 32'd0);

    // flush coinciding with head retire still writes
    cyc();
    expect_wr(5'd20, 32'h0000_BEEF);
    push(32'h400, LD_NONE, 1'b1, 5'd20, 32'hBEEF, 2'd0, 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ret_count", 32'(count), 32'd0);

    cyc();
    resp(32'h0);
    @(negedge clk);
    chk("stray_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    chk("stray_err_sticky", 32'(err), 32'd1);

    // reset while an output write and a queued load are live
    cyc();
    expect_wr(5'd21, 32'h0000_0055);
    push(32'h500, LD_NONE, 1'b1, 5'd21, 32'h55, 2'd0, 32'd0);
    push(32'h504, LD_W, 1'b1, 5'd22, 32'd0, 2'd0, 32'd0);
    @(negedge clk);
    chk("pre_rst_rf_wen", 32'(rf_wen), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_busy", busy_mask, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

In-order writeback/retire unit for the MIPS pipeline. It replaces the single-slot writeback stage with a parametrised queue of up to DEPTH in-flight instructions, so that several loads and stores can be outstanding on the data bus at once. It aligns load data (including LWL/LWR merge), retires instructions strictly in program order into the register file, and exports a pending-write scoreboard for hazard detection.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; a power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage offers an instruction.
- in_ready  out  1  the queue accepts the offered instruction.
- in_pc  in  32  instruction PC.
- in_ldop  in  4  load/store class, a wb_pkg ld_op_t value.
- in_wen  in  1  the instruction writes a register.
- in_waddr  in  5  destination register.
- in_result  in  32  ALU result, used for non-load instructions.
- in_eoff  in  2  effective-address bits [1:0].
- in_rtold  in  32  old rt value, used for the LWL/LWR merge.
- flush  in  1  kill all queued instructions.
- data_rdata  in  32  load data from the bus.
- data_data_ok  in  1  bus completion; responses arrive in request order.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  5  write address (registered).
- rf_wdata  out  32  write data (registered).
- retire_valid  out  1  an instruction retired last cycle (registered).
- retire_pc  out  32  PC of that instruction.
- busy_mask  out  32  registers with a pending write.
- count  out  CNT_W  current occupancy.
- err  out  1  sticky flag: data_data_ok arrived with no mem entry at the head.

## Operation
- Storage is a circular FIFO: head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count.
- Push happens when in_valid && in_ready. in_ready = (count != DEPTH) && !flush.
- Each entry holds pc, ldop, wen, waddr, result, eoff, rtold, and a kill bit.
- Retire condition at the head:
  - ldop == LD_NONE: retires unconditionally.
  - memory op (loads or LD_ST): retires only in a cycle with data_data_ok.
- Retire rate is at most one entry per cycle; there is no reordering.
- Load data is formed by wb_load_align:
  - LB/LBU, LH/LHU: shift right by 8*eoff, then sign- or zero-extend.
  - LW: taken unchanged.
  - LWL: (rdata << 8*~eoff) merged over rtold under mask (ones << 8*~eoff).
  - LWR: (rdata >> 8*eoff) merged over rtold under mask (ones >> 8*eoff).
- Write data selection: LD_NONE uses result; loads use the aligned data; LD_ST never writes.
- Register write happens on retire when the entry has wen=1, kill=0 and is not LD_ST. A write to waddr 0 is issued but never marks busy.
- flush: every valid entry gets kill=1.
  - Killed LD_NONE entries still drain at one per cycle, with no write.
  - Killed memory entries still wait for, and consume, their data_data_ok.
- busy_mask is the OR of one-hot(waddr) over valid, unkilled, wen entries, plus the output register when rf_wen=1. Bit 0 is always 0.
- err: set when data_data_ok=1 and the head is empty or LD_NONE. The stray response is dropped. err is cleared only by reset.

## Timing
- Reset values: all outputs 0, except in_ready = 1. Pointers, count, kill bits and err are 0.
- Push in cycle t: the entry can be at the head in t+1; rf_* and retire_* are asserted in t+2 at the earliest.
- A load whose data_data_ok arrives in cycle u retires in u and writes the register file in u+1.
- Push and retire in the same cycle: count is unchanged. When full, in_ready stays 0 even if a retire happens in the same cycle.
- flush in the same cycle as a retire: the retiring head still writes, because kill takes effect from t+1.
- Reset mid-operation: the queue empties immediately. Responses outstanding at reset belong to the bus owner, which is reset together with this block.

## Configuration
- WB_BYPASS_EN defined:
  - Applies when count == 0, in_valid=1, in_ldop == LD_NONE, and flush=0.
  - The instruction retires in the same cycle without being enqueued; rf_* is asserted at t+1.
- WB_BYPASS_EN undefined: every instruction passes through the queue, with minimum latency t+2.

## Structure
- Package wb_pkg holds:
  - the ld_op_t enum: LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU, LD_WL, LD_WR, LD_ST;
  - the entry struct typedef;
  - a function mapping decoded control bits to ld_op_t.
- Sub-module wb_load_align: combinational alignment and merge (ldop, eoff, rdata, rtold -> wdata).
- Top level contains the FIFO, retire control, scoreboard and output registers.

## Test plan
- Push ADDU (waddr 5, result 0x1234), queue empty, bypass off -> rf_wen=1, waddr 5, wdata 0x1234 in t+2. busy_mask[5]=1 from t+1 through t+2.
- Push LB with eoff=3, rdata=0x80FF_FF00 -> wdata 0xFFFF_FF80. Same case as LBU -> 0x0000_0080.
- LWL with eoff=1, rdata=0xAABBCCDD, rtold=0x11223344 -> 0xCCDD3344. LWR with eoff=2, same data -> 0x1122AABB.
- Fill DEPTH=4 loads: in_ready=0 and count=4. Four data_ok pulses on consecutive cycles -> four writes in program order, and in_ready=1 after the first retire.
- Two loads queued, flush, then two data_ok pulses -> no rf_wen, count reaches 0, err stays 0.
- data_data_ok with an empty queue -> err=1 until reset. Asserting reset mid-queue -> count=0 and rf_wen=0 immediately.
